// File: rtl/axi_ram_resp_pkg.sv
// Shared AXI encodings and engine state types for the AXI RAM responder.
package axi_ram_resp_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat address for one AXI burst; reserved burst type behaves as INCR.
module axi_burst_addr
    import axi_ram_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        incr      = ADDR_WIDTH'(1) << size;
        // Window is (len+1)<<size bytes, aligned to its own size.
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
            default:     next_addr = addr + incr;
        endcase
    end

endmodule

// File: rtl/axi_ram_resp.sv
// AXI4 slave RAM with independent write and read burst engines over a dual-port word array.
module axi_ram_resp
    import axi_ram_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int LANE_BITS = $clog2(STRB_WIDTH);
    localparam int WORDS     = 2 ** (ADDR_WIDTH - LANE_BITS);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // Burst length comes from awlen alone, so wlast carries no information here.
    logic unused_wlast;
    assign unused_wlast = s_axi_wlast;

    wstate_t               wstate, wnext;
    logic [ID_WIDTH-1:0]   wid;
    logic [ADDR_WIDTH-1:0] waddr, waddr_nxt;
    logic [7:0]            wlen, wcnt;
    logic [2:0]            wsize;
    logic [1:0]            wburst;
    logic                  aw_hs, w_hs, b_hs;

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
        .addr      (waddr),
        .len       (wlen),
        .size      (wsize),
        .burst     (wburst),
        .next_addr (waddr_nxt)
    );

    always_comb begin
        aw_hs = s_axi_awvalid && s_axi_awready;
        w_hs  = s_axi_wvalid && s_axi_wready;
        b_hs  = s_axi_bvalid && s_axi_bready;
        wnext = wstate;
        case (wstate)
            W_IDLE:  if (aw_hs) wnext = W_DATA;
            W_DATA:  if (w_hs && wcnt == 8'd0) wnext = W_RESP;
            W_RESP:  if (b_hs) wnext = W_IDLE;
            default: wnext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate        <= W_IDLE;
            wid           <= '0;
            waddr         <= '0;
            wlen          <= '0;
            wcnt          <= '0;
            wsize         <= '0;
            wburst        <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
        end else begin
            wstate        <= wnext;
            s_axi_awready <= (wnext == W_IDLE);
            s_axi_wready  <= (wnext == W_DATA);
            s_axi_bvalid  <= (wnext == W_RESP);
            if (aw_hs) begin
                wid    <= s_axi_awid;
                waddr  <= s_axi_awaddr;
                wlen   <= s_axi_awlen;
                wcnt   <= s_axi_awlen;
                wsize  <= s_axi_awsize;
                wburst <= s_axi_awburst;
            end else if (w_hs) begin
                waddr <= waddr_nxt;
                wcnt  <= wcnt - 8'd1;
            end
        end
    end

    // A beat landing on the reset edge belongs to the aborted burst and is dropped.
    always_ff @(posedge clk) begin
        if (w_hs && !rst) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b])
                    mem[waddr[ADDR_WIDTH-1:LANE_BITS]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    assign s_axi_bid   = wid;
    assign s_axi_bresp = RESP_OKAY;

    rstate_t               rstate, rnext;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [ADDR_WIDTH-1:0] raddr, raddr_nxt;
    logic [7:0]            rlen, rcnt;
    logic [2:0]            rsize;
    logic [1:0]            rburst;
    logic                  ar_hs, r_issue, rvalid_d;

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
        .addr      (raddr),
        .len       (rlen),
        .size      (rsize),
        .burst     (rburst),
        .next_addr (raddr_nxt)
    );

    always_comb begin
        ar_hs    = s_axi_arvalid && s_axi_arready;
        r_issue  = (rstate == R_DATA) && (!s_axi_rvalid || s_axi_rready);
        rnext    = rstate;
        rvalid_d = s_axi_rvalid;
        case (rstate)
            R_IDLE:  if (ar_hs) rnext = R_DATA;
            R_DATA:  if (r_issue && rcnt == 8'd0) rnext = R_IDLE;
            default: rnext = R_IDLE;
        endcase
        if (r_issue)
            rvalid_d = 1'b1;
        else if (s_axi_rvalid && s_axi_rready)
            rvalid_d = 1'b0;
    end

    // arready waits for the final beat to be accepted, not just issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate        <= R_IDLE;
            rid_q         <= '0;
            raddr         <= '0;
            rlen          <= '0;
            rcnt          <= '0;
            rsize         <= '0;
            rburst        <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            rstate        <= rnext;
            s_axi_arready <= (rnext == R_IDLE) && !rvalid_d;
            s_axi_rvalid  <= rvalid_d;
            if (ar_hs) begin
                rid_q  <= s_axi_arid;
                raddr  <= s_axi_araddr;
                rlen   <= s_axi_arlen;
                rcnt   <= s_axi_arlen;
                rsize  <= s_axi_arsize;
                rburst <= s_axi_arburst;
            end else if (r_issue) begin
                s_axi_rdata <= mem[raddr[ADDR_WIDTH-1:LANE_BITS]];
                s_axi_rlast <= (rcnt == 8'd0);
                raddr       <= raddr_nxt;
                rcnt        <= rcnt - 8'd1;
            end
        end
    end

    assign s_axi_rid   = rid_q;
    assign s_axi_rresp = RESP_OKAY;

endmodule

// File: tb/tb_axi_ram_resp.sv
// Directed scoreboard bench for axi_ram_resp with a byte-level reference memory.
module tb_axi_ram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awid, arid, bid, rid;
    logic [15:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    logic [7:0]  model [0:65535];
    logic [31:0] rq [$];
    logic [7:0]  bq [$];

    axi_ram_resp dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address of beat i computed directly from the burst start.
    function automatic logic [15:0] beat_addr(input logic [15:0] start, input int i,
                                              input logic [7:0] len, input logic [2:0] size,
                                              input logic [1:0] burst);
        int step, total, base, off;
        step  = 1 << size;
        total = (int'(len) + 1) * step;
        case (burst)
            2'b00: return start;
            2'b10: begin
                base = (int'(start) / total) * total;
                off  = (int'(start) - base + i * step) % total;
                return 16'(base + off);
            end
            default: return 16'(int'(start) + i * step);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [31:0] first, input logic [3:0] strb, output int cycles);
        int start, w;
        logic [15:0] a;
        logic [31:0] d;
        start = cyc_cnt;
        cycles = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        w = 0;
        while (!awready && w < 50) begin tick(); w++; end
        if (!awready) begin chk("aw_timeout", 0, 1); awvalid = 1'b0; return; end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            d = first + 32'(i);
            wdata = d; wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
            a = beat_addr(addr, i, len, size, burst) & 16'hFFFC;
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[a + 16'(b)] = d[b*8 +: 8];
            w = 0;
            while (!wready && w < 50) begin tick(); w++; end
            if (!wready) begin chk("w_timeout", 0, 1); wvalid = 1'b0; return; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        bq.push_back(id);
        bready = 1'b1;
        w = 0;
        while (!bvalid && w < 50) begin tick(); w++; end
        if (!bvalid) begin chk("b_timeout", 0, 1); void'(bq.pop_front()); return; end
        chk("bid", bid, bq.pop_front());
        chk("bresp", bresp, 2'b00);
        tick();
        chk("aw_rearm", awready, 1);
        cycles = cyc_cnt - start;
    endtask

    task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [31:0] stall, input bit chk_lat, output int cycles);
        int start, w, got, c, nb;
        logic [15:0] a;
        logic [31:0] held, exp;
        bit was_stall;
        start = cyc_cnt;
        cycles = 0;
        nb = int'(len) + 1;
        for (int i = 0; i < nb; i++) begin
            a = beat_addr(addr, i, len, size, burst) & 16'hFFFC;
            rq.push_back({model[a + 16'd3], model[a + 16'd2], model[a + 16'd1], model[a]});
        end
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        w = 0;
        while (!arready && w < 50) begin tick(); w++; end
        if (!arready) begin chk("ar_timeout", 0, 1); arvalid = 1'b0; rq.delete(); return; end
        tick();
        arvalid = 1'b0;
        rready = !stall[0];
        if (chk_lat) begin
            chk("r_lat_0", rvalid, 0);
            tick();
            chk("r_lat_1", rvalid, 1);
        end
        got = 0; c = 0; was_stall = 0; held = '0;
        while (got < nb && c < 200) begin
            rready = !stall[c % 32];
            if (rvalid) begin
                if (was_stall) chk("r_stable", rdata, held);
                if (rready) begin
                    exp = rq.pop_front();
                    chk("rdata", rdata, exp);
                    chk("rlast", rlast, got == nb - 1);
                    chk("rid", rid, id);
                    got++;
                    was_stall = 0;
                end else begin
                    held = rdata;
                    was_stall = 1;
                end
            end
            tick();
            c++;
        end
        rready = 1'b1;
        if (got < nb) begin chk("r_timeout", got, nb); rq.delete(); end
        chk("r_drained", rvalid, 0);
        cycles = cyc_cnt - start;
    endtask

    initial begin
        int wc, rc, seen_b;
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b1;
        repeat (3) tick();
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ids", {bid, rid}, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_awready", awready, 1);
        chk("post_rst_arready", arready, 1);

        // INCR write then read-back with latency check
        do_write(8'h5A, 16'h0100, 8'd3, 3'd2, 2'b01, 32'h0000_00A0, 4'hF, wc);
        do_read(8'h3C, 16'h0100, 8'd3, 3'd2, 2'b01, 32'h0, 1'b1, rc);

        // WRAP read: 0x108, 0x10C, 0x100, 0x104
        do_read(8'h11, 16'h0108, 8'd3, 3'd2, 2'b10, 32'h0, 1'b0, rc);

        // FIXED narrow write: only byte 0 moves, ending at the last beat's value
        do_write(8'h01, 16'h0020, 8'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, 4'hF, wc);
        do_write(8'h02, 16'h0020, 8'd3, 3'd0, 2'b00, 32'hFFFF_FF10, 4'h1, wc);
        do_read(8'h03, 16'h0020, 8'd0, 3'd2, 2'b01, 32'h0, 1'b0, rc);

        // 8-beat read with rready stalls
        do_write(8'h04, 16'h0200, 8'd7, 3'd2, 2'b01, 32'h2000_0000, 4'hF, wc);
        do_read(8'h05, 16'h0200, 8'd7, 3'd2, 2'b01, 32'h0000_0034, 1'b0, rc);

        // Concurrent 16-beat write and read on disjoint regions
        do_write(8'h06, 16'h0600, 8'd15, 3'd2, 2'b01, 32'h6000_0000, 4'hF, wc);
        fork
            begin do_write(8'h07, 16'h0400, 8'd15, 3'd2, 2'b01, 32'h4000_0000, 4'hF, wc); end
            begin do_read(8'h08, 16'h0600, 8'd15, 3'd2, 2'b01, 32'h0, 1'b0, rc); end
        join
        chk("conc_wr_cycles_le18", (wc > 0 && wc <= 18), 1);
        chk("conc_rd_cycles_le18", (rc > 0 && rc <= 18), 1);

        // Reset on beat 2 of a 4-beat write
        awid = 8'h09; awaddr = 16'h0800; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata = 32'h8888_0000; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wdata = 32'h8888_0001;
        rst = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("midrst_awready", awready, 0);
        chk("midrst_wready", wready, 0);
        chk("midrst_bvalid", bvalid, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rel_awready", awready, 1);
        seen_b = 0;
        for (int i = 0; i < 4; i++) begin
            if (bvalid) seen_b++;
            tick();
        end
        chk("abort_no_b", seen_b, 0);

        // Memory survives reset
        do_read(8'h0A, 16'h0100, 8'd0, 3'd2, 2'b01, 32'h0, 1'b0, rc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
